// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: locks to the frame marker, collects four
// slots into shadow registers and publishes them together with a valid strobe.
module tdm_demux4 #(
  parameter int unsigned W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   din,
  input  logic           en,
  input  logic           frame,
  output logic [4*W-1:0] out,
  output logic           valid,
  output logic [1:0]     slot,
  output logic           locked,
  output logic           sync_err
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t         state, state_n;
  logic [1:0]     slot_n;
  logic [W-1:0]   sh0, sh1, sh2;
  logic [W-1:0]   sh0_n, sh1_n, sh2_n;
  logic [4*W-1:0] out_n;
  logic           valid_n, sync_err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      slot     <= '0;
      sh0      <= '0;
      sh1      <= '0;
      sh2      <= '0;
      out      <= '0;
      valid    <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_n;
      slot     <= slot_n;
      sh0      <= sh0_n;
      sh1      <= sh1_n;
      sh2      <= sh2_n;
      out      <= out_n;
      valid    <= valid_n;
      sync_err <= sync_err_n;
    end
  end

  always_comb begin
    state_n    = state;
    slot_n     = slot;
    sh0_n      = sh0;
    sh1_n      = sh1;
    sh2_n      = sh2;
    out_n      = out;
    valid_n    = 1'b0;
    sync_err_n = 1'b0;
    if (en) begin
      unique case (state)
        HUNT: begin
          if (frame) begin
            sh0_n   = din;
            slot_n  = 2'd1;
            state_n = LOCK;
          end
        end
        LOCK: begin
          if (slot == 2'd0) begin
            if (frame) begin
              sh0_n  = din;
              slot_n = 2'd1;
            end else begin
              sync_err_n = 1'b1;
              slot_n     = 2'd0;
              state_n    = HUNT;
            end
          end else if (frame) begin
            // Early marker: restart the frame on this sample; stale shadow
            // entries 1/2 are always rewritten before the next publish.
            sync_err_n = 1'b1;
            sh0_n      = din;
            slot_n     = 2'd1;
          end else if (slot == 2'd3) begin
            out_n   = {din, sh2, sh1, sh0};
            valid_n = 1'b1;
            slot_n  = 2'd0;
          end else begin
            if (slot == 2'd1) sh1_n = din;
            else              sh2_n = din;
            slot_n = slot + 2'd1;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCK);

endmodule
